// File: rtl/fpa_pkg.sv
// rtl/fpa_pkg.sv - shared state encoding, widths and constants for the fp adder arbiter
package fpa_pkg;

  localparam int FP32_W = 32;
  localparam int FP16_W = 16;

  localparam logic [FP32_W-1:0] FP32_ONE = 32'h3F80_0000;
  localparam logic [FP16_W-1:0] FP16_ONE = 16'h3C00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Half-precision values live in the low 16 bits; the upper half is forced to zero.
  function automatic logic [FP32_W-1:0] half_mask(input logic [FP32_W-1:0] v, input logic half);
    return half ? {{(FP32_W-FP16_W){1'b0}}, v[FP16_W-1:0]} : v;
  endfunction

endpackage

// File: rtl/fpa_rr_arbiter_rr_pick.sv
// rtl/fpa_rr_arbiter_rr_pick.sv - combinational round-robin picker, search starts at ptr+1
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any_req
);

  int idx;

  // Walk from farthest to nearest so the nearest requester after ptr overwrites the rest.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any_req  = |req;
    idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fpa_rr_arbiter.sv
// rtl/fpa_rr_arbiter.sv - round-robin sequencer sharing one fp adder among NREQ requesters
// Optional statistics outputs (op_count, last_half) enabled by FPA_ARB_STATS_EN.
module fpa_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]   req_half,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [31:0]       resp_sum,
  output logic [IDW-1:0]    resp_id,
  output logic              busy,
  output logic [31:0]       fpa_a,
  output logic [31:0]       fpa_b,
  output logic              fpa_sel,
`ifdef FPA_ARB_STATS_EN
  output logic [15:0]       op_count,
  output logic              last_half,
`endif
  input  logic [31:0]       fpa_sum
);

  import fpa_pkg::*;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic            half_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            any_req;
  logic            accept;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            sel_half;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  assign accept    = (state == IDLE) && any_req;
  assign req_ready = (state == IDLE && !rst) ? grant : '0;

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_half = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a    = req_a[32*i +: 32];
        sel_b    = req_b[32*i +: 32];
        sel_half = req_half[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= IDW'(NREQ - 1);
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      half_q   <= 1'b0;
      resp_sum <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q    <= half_mask(sel_a, sel_half);
          b_q    <= half_mask(sel_b, sel_half);
          half_q <= sel_half;
          id_q   <= grant_id;
          rr_ptr <= grant_id;
          state  <= EXEC;
        end
        EXEC: begin
          resp_sum <= half_mask(fpa_sum, half_q);
          state    <= RESP;
        end
        RESP: if (resp_ready[id_q]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operands come straight from registers, so the adder inputs stay stable through RESP.
  assign busy       = (state != IDLE);
  assign fpa_a      = busy ? a_q : '0;
  assign fpa_b      = busy ? b_q : '0;
  assign fpa_sel    = busy ? half_q : 1'b0;
  assign resp_valid = (state == RESP) ? (NREQ'(1) << id_q) : '0;
  assign resp_id    = id_q;

`ifdef FPA_ARB_STATS_EN
  logic done_hs;
  assign done_hs = (state == RESP) && resp_ready[id_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= '0;
      last_half <= 1'b0;
    end else if (done_hs) begin
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      last_half <= half_q;
    end
  end
`endif

endmodule
